// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//   Word-addressed data memory with DATA_W-bit words and 2**ADDR_W entries.
//   Writes happen on the rising clock edge. Reads are combinational.
//   An asynchronous active-low reset clears every word.
//
// Parameters
//   DATA_W   word width in bits (default 32)
//   ADDR_W   word-address width; depth = 2**ADDR_W (default 6 -> 64 words)
//
// Ports (positional order is fixed)
//   clk       in   clock; all writes on its rising edge
//   MemRead   in   read enable; data_out is 0 while low
//   MemWrite  in   write enable
//   addr      in   word address (not byte-addressed)
//   data_in   in   write data
//   data_out  out  combinational read data
//   rst_n     in   asynchronous active-low reset
//
// Build option
//   DATA_MEMORY_WR_FWD_EN  when defined, a simultaneous read and write
//                          forwards data_in to data_out before the edge.
//                          When undefined, the old contents are shown.
// ---------------------------------------------------------------------------
module data_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              rst_n
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: every word is cleared while reset is held, so reads of
    // never-written words return 0 rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            mem[addr] <= data_in;
        end
    end

    // Read path: gated by MemRead and by reset so the output is 0 from the
    // instant reset asserts.
    always_comb begin
        data_out = '0;
        if (rst_n && MemRead) begin
`ifdef DATA_MEMORY_WR_FWD_EN
            if (MemWrite) begin
                data_out = data_in;
            end else begin
                data_out = mem[addr];
            end
`else
            data_out = mem[addr];
`endif
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory
//   Directed self-checking bench for data_memory. Inputs change on the
//   falling edge; outputs are sampled 1 time unit after a change or edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_memory;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    int total;
    int passed;

    data_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] exp);
        total++;
        assert (data_out === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
    endtask

    // Set address/read enable between edges and sample the combinational output.
    task automatic read_at(input logic [ADDR_W-1:0] a, input logic rd);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = rd;
        addr     = a;
        #1;
    endtask

    // One write edge with MemRead low.
    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        addr     = a;
        data_in  = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    logic [DATA_W-1:0] pre_edge_exp;

    initial begin
        total    = 0;
        passed   = 0;
        rst_n    = 1'b0;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        addr     = '0;
        data_in  = '0;
        #1;

        // Reset state at several addresses
        addr = 6'd0;  #1; check("rst_addr0", 32'd0);
        addr = 6'd2;  #1; check("rst_addr2", 32'd0);
        addr = 6'd6;  #1; check("rst_addr6", 32'd0);
        addr = 6'd63; #1; check("rst_addr63", 32'd0);

        // Writes ignored during reset, even with clocks running
        @(negedge clk);
        MemWrite = 1'b1;
        addr     = 6'd2;
        data_in  = 32'hAAAA5555;
        @(posedge clk);
        #1;
        check("rst_write_ignored_out", 32'd0);
        @(negedge clk);
        MemWrite = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_write_ignored_mem", 32'd0);

        // Write then read
        write_word(6'd2, 32'd4);
        read_at(6'd2, 1'b1);
        check("wr_rd_addr2", 32'd4);

        // Second location, first unchanged
        write_word(6'd6, 32'd2);
        read_at(6'd6, 1'b1);
        check("wr_rd_addr6", 32'd2);
        read_at(6'd2, 1'b1);
        check("addr2_kept", 32'd4);

        // Read gating
        read_at(6'd2, 1'b0);
        check("read_gated", 32'd0);

        // Top address, full-width pattern
        write_word(6'd63, 32'hDEADBEEF);
        read_at(6'd63, 1'b1);
        check("wr_rd_addr63", 32'hDEADBEEF);
        read_at(6'd0, 1'b1);
        check("addr0_untouched", 32'd0);

        // Simultaneous read and write to addr 6
`ifdef DATA_MEMORY_WR_FWD_EN
        pre_edge_exp = 32'd9;
`else
        pre_edge_exp = 32'd2;
`endif
        @(negedge clk);
        addr     = 6'd6;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        data_in  = 32'd9;
        #1;
        check("rdwr_pre_edge", pre_edge_exp);
        @(posedge clk);
        #1;
        check("rdwr_post_edge", 32'd9);
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        check("rdwr_stored", 32'd9);

        // No change without MemWrite, even with data_in moving across an edge
        @(negedge clk);
        addr    = 6'd63;
        data_in = 32'h12345678;
        @(posedge clk);
        #1;
        check("no_write_hold", 32'hDEADBEEF);

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_addr63", 32'd0);
        read_at(6'd2, 1'b1);
        check("post_rst_addr2", 32'd0);
        read_at(6'd6, 1'b1);
        check("post_rst_addr6", 32'd0);

        // First edge after reset release performs a normal write
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b1;
        addr     = 6'd5;
        data_in  = 32'h0BADF00D;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_at(6'd5, 1'b1);
        check("first_edge_write", 32'h0BADF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 6, word-address width; depth = 2**ADDR_W (64 words).
REQ-003 clk  input  1  single clock; all writes occur on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 MemRead  input  1  read enable.
REQ-006 MemWrite  input  1  write enable.
REQ-007 addr  input  ADDR_W  word address, 0..63; not byte-addressed.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 data_out  output  DATA_W  read data.
REQ-010 Positional port order SHALL be clk, MemRead, MemWrite, addr, data_in, data_out, rst_n, so six-port positional instances still bind correctly.
REQ-011 The design SHALL use one clock (clk) and one reset (rst_n); reset is asynchronous and active-low.

Function
REQ-012 Storage SHALL be 2**ADDR_W words of DATA_W bits each.
- On a rising clk edge with rst_n=1 and MemWrite=1, mem[addr] <= data_in.
REQ-013 Write SHALL occur regardless of MemRead.
REQ-014 With MemWrite=0, no word SHALL change.
REQ-015 Read SHALL be combinational, with zero-cycle latency.
- data_out = mem[addr] while MemRead=1.
- data_out = 0 while MemRead=0.
REQ-016 A write SHALL become visible on data_out in the same cycle the write edge occurs.
- Read of an address SHALL return the new value from the first delta after that edge.
REQ-017 Simultaneous MemRead=1 and MemWrite=1 to the same address before the edge:
- data_out SHALL show the old contents.
- Exception: forwarding per REQ-024.
REQ-018 All addr values SHALL be legal; there is no wrap-around, out-of-range or error condition.
REQ-019 No X SHALL propagate to data_out from unwritten words, because reset initializes all words.

Reset
REQ-020 While rst_n=0, every memory word SHALL be 0, asynchronously, independent of clk.
REQ-021 While rst_n=0, data_out SHALL be 0.
REQ-022 Writes SHALL be ignored while rst_n=0.
- A write edge coincident with reset assertion is lost.
REQ-023 After rst_n deasserts, the first rising clk edge SHALL perform a normal write if MemWrite=1.

Configuration
REQ-024 Macro DATA_MEMORY_WR_FWD_EN:
- When defined: if MemRead=1, MemWrite=1 and rst_n=1, data_out SHALL equal data_in combinationally, before the edge.
- When undefined: behaviour per REQ-017.

Verification
REQ-025 Reset: rst_n=0 -> data_out=0 for addr 0, 2, 6 and 63 with MemRead=1.
REQ-026 Write then read:
- addr=2, MemWrite=1, data_in=4, one edge.
- Then MemWrite=0, MemRead=1.
- Required: data_out=4.
REQ-027 Second location:
- addr=6, write data_in=2, then read.
- Required: data_out=2; addr 2 still reads 4.
REQ-028 Read gating: MemRead=0 at addr=2 (holding 4) -> data_out=0.
- Write 0xDEADBEEF at addr=63, read -> 0xDEADBEEF.
REQ-029 Simultaneous access: addr=6 holds 2; MemRead=1, MemWrite=1, data_in=9.
- Before the edge: data_out=2 without DATA_MEMORY_WR_FWD_EN, 9 with it.
- After the edge: data_out=9 in both builds.
REQ-030 Async reset mid-run: assert rst_n=0 between edges -> data_out=0 immediately.
- After release, addr 2 and addr 6 both read 0.
